// File: rtl/sc_gametick_sequencer.sv
// Game pacing and phase scheduler for the lane-game datapath.
// Divides CLOCK_50 into game ticks, keeps the 8-bit tick count (reloj), tracks
// the phase window the count is in, and sequences start / pause / collision.
// Each completed round shortens the tick period down to a floor (level speed-up).
// The phase boundary table can be rewritten through the config port while idle.
module sc_gametick_sequencer #(
    parameter int PRESCALE_W     = 26,
    parameter int DEFAULT_PERIOD = 25000000,
    parameter int MIN_PERIOD     = 3125000,
    parameter int SPEEDUP_STEP   = 1562500,
    parameter int ROUND_LEN      = 154,
    parameter int NUM_BOUNDS     = 9
) (
    input  logic       SC_GAMESEQ_CLOCK_50,
    input  logic       SC_GAMESEQ_RESET_InLow,
    input  logic       SC_GAMESEQ_startButton_InLow,
    input  logic       SC_GAMESEQ_pauseButton_InLow,
    input  logic       SC_GAMESEQ_collision_InHigh,
    input  logic       SC_GAMESEQ_cfgWr_InHigh,
    input  logic [3:0] SC_GAMESEQ_cfgAddr,
    input  logic [7:0] SC_GAMESEQ_cfgData,
    output logic       SC_GAMESEQ_cfgAck_Out,
    output logic [7:0] SC_GAMESEQ_reloj_Out,
    output logic       SC_GAMESEQ_tick_Out,
    output logic [3:0] SC_GAMESEQ_phase_Out,
    output logic       SC_GAMESEQ_phaseStart_Out,
    output logic [2:0] SC_GAMESEQ_level_Out,
    output logic [7:0] SC_GAMESEQ_round_Out,
    output logic       SC_GAMESEQ_running_Out,
    output logic       SC_GAMESEQ_lost_Out
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_RUN,
        ST_PAUSE,
        ST_LOST
    } state_t;

    localparam logic [PRESCALE_W-1:0] PERIOD_RST  = PRESCALE_W'(DEFAULT_PERIOD);
    localparam logic [PRESCALE_W-1:0] PERIOD_MIN  = PRESCALE_W'(MIN_PERIOD);
    localparam logic [PRESCALE_W-1:0] PERIOD_STEP = PRESCALE_W'(SPEEDUP_STEP);
    // Smallest period that can still take a full step without dropping below the floor.
    localparam logic [PRESCALE_W-1:0] PERIOD_KNEE = PRESCALE_W'(MIN_PERIOD + SPEEDUP_STEP);
    localparam logic [PRESCALE_W-1:0] PRESCALE_ONE = PRESCALE_W'(1);
    localparam logic [7:0]            RELOJ_LAST  = 8'(ROUND_LEN - 1);
    localparam logic [3:0]            BOUND_CNT   = 4'(NUM_BOUNDS);

    // Power-up phase boundaries for the stock lane layout.
    function automatic logic [7:0] default_bound(input int idx);
        case (idx)
            0:       return 8'd8;
            1:       return 8'd24;
            2:       return 8'd44;
            3:       return 8'd52;
            4:       return 8'd60;
            5:       return 8'd90;
            6:       return 8'd98;
            7:       return 8'd106;
            8:       return 8'd146;
            default: return 8'd255;
        endcase
    endfunction

    state_t                state;
    logic [PRESCALE_W-1:0] prescaler;
    logic [PRESCALE_W-1:0] period;
    logic [7:0]            bound [NUM_BOUNDS];
    logic                  pause_prev;
    logic [7:0]            reloj;
    logic [3:0]            phase;
    logic [2:0]            level;
    logic [7:0]            round;
    logic                  tick;
    logic                  phase_start;
    logic                  cfg_ack;

    logic                  pause_fall;
    logic                  terminal;
    logic [7:0]            reloj_inc;
    logic                  bound_hit;

    assign pause_fall = pause_prev & ~SC_GAMESEQ_pauseButton_InLow;
    assign terminal   = (prescaler == period - PRESCALE_ONE);
    assign reloj_inc  = reloj + 8'd1;

    // Does the count about to be entered open the next phase window?
    always_comb begin
        // NOTE: default first so no path leaves bound_hit unassigned (no latch).
        bound_hit = 1'b0;
        if (phase < BOUND_CNT) begin
            bound_hit = (reloj_inc == bound[phase]);
        end
    end

    // Sequencer FSM, prescaler, counters, boundary table and all pulse outputs.
    always_ff @(posedge SC_GAMESEQ_CLOCK_50 or negedge SC_GAMESEQ_RESET_InLow) begin
        if (!SC_GAMESEQ_RESET_InLow) begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            state       <= ST_IDLE;
            prescaler   <= '0;
            period      <= PERIOD_RST;
            pause_prev  <= 1'b1;
            reloj       <= '0;
            phase       <= '0;
            level       <= '0;
            round       <= '0;
            tick        <= 1'b0;
            phase_start <= 1'b0;
            cfg_ack     <= 1'b0;
            // NOTE: the table is flops, not RAM, so reset can restore the stock layout.
            for (int i = 0; i < NUM_BOUNDS; i++) begin
                bound[i] <= default_bound(i);
            end
        end else begin
            tick        <= 1'b0;
            phase_start <= 1'b0;
            cfg_ack     <= 1'b0;
            pause_prev  <= SC_GAMESEQ_pauseButton_InLow;

            case (state)
                ST_IDLE: begin
                    if (SC_GAMESEQ_cfgWr_InHigh && (SC_GAMESEQ_cfgAddr < BOUND_CNT)) begin
                        bound[SC_GAMESEQ_cfgAddr] <= SC_GAMESEQ_cfgData;
                        cfg_ack                   <= 1'b1;
                    end
                    if (!SC_GAMESEQ_startButton_InLow) begin
                        state <= ST_ARMED;
                    end
                end

                ST_ARMED: begin
                    // Game starts on release so one press cannot also count as a pause.
                    if (SC_GAMESEQ_startButton_InLow) begin
                        state       <= ST_RUN;
                        reloj       <= '0;
                        phase       <= '0;
                        prescaler   <= '0;
                        phase_start <= 1'b1;
                    end
                end

                ST_RUN: begin
                    if (SC_GAMESEQ_collision_InHigh) begin
                        // Collision wins: the coincident tick is dropped entirely.
                        state <= ST_LOST;
                    end else begin
                        if (terminal) begin
                            prescaler <= '0;
                            tick      <= 1'b1;
                            if (reloj == RELOJ_LAST) begin
                                reloj       <= '0;
                                phase       <= '0;
                                phase_start <= 1'b1;
                                round       <= round + 8'd1;
                                if (level != 3'd7) begin
                                    level <= level + 3'd1;
                                end
                                period <= (period >= PERIOD_KNEE) ? (period - PERIOD_STEP)
                                                                  : PERIOD_MIN;
                            end else begin
                                reloj <= reloj_inc;
                                if (bound_hit) begin
                                    phase       <= phase + 4'd1;
                                    phase_start <= 1'b1;
                                end
                            end
                        end else begin
                            prescaler <= prescaler + PRESCALE_ONE;
                        end
                        // A tick in the same cycle as the pause edge still counts.
                        if (pause_fall) begin
                            state <= ST_PAUSE;
                        end
                    end
                end

                ST_PAUSE: begin
                    if (pause_fall) begin
                        state <= ST_RUN;
                    end
                end

                ST_LOST: begin
                    if (!SC_GAMESEQ_startButton_InLow) begin
                        state  <= ST_ARMED;
                        level  <= '0;
                        round  <= '0;
                        period <= PERIOD_RST;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign SC_GAMESEQ_cfgAck_Out     = cfg_ack;
    assign SC_GAMESEQ_reloj_Out      = reloj;
    assign SC_GAMESEQ_tick_Out       = tick;
    assign SC_GAMESEQ_phase_Out      = phase;
    assign SC_GAMESEQ_phaseStart_Out = phase_start;
    assign SC_GAMESEQ_level_Out      = level;
    assign SC_GAMESEQ_round_Out      = round;
    assign SC_GAMESEQ_running_Out    = (state == ST_RUN);
    assign SC_GAMESEQ_lost_Out       = (state == ST_LOST);

endmodule

// File: tb/tb_sc_gametick_sequencer.sv
// Bench for sc_gametick_sequencer with a short tick period.
// A reference model derives expected behaviour from the game rules (ticks per
// elapsed run time, phase = number of boundaries already reached, level and
// round from the count of completed rounds) and queues expected pulses; a
// monitor pops and compares them whenever the DUT pulses, and compares the
// steady outputs every cycle.
module tb_sc_gametick_sequencer;

    localparam int DEF  = 4;
    localparam int MINP = 2;
    localparam int STEP = 1;
    localparam int RLEN = 154;
    localparam int NB   = 9;
    localparam int DEF_TBL [NB] = '{8, 24, 44, 52, 60, 90, 98, 106, 146};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_n = 1'b1;
    logic       pause_n = 1'b1;
    logic       coll = 1'b0;
    logic       cfg_wr = 1'b0;
    logic [3:0] cfg_addr = '0;
    logic [7:0] cfg_data = '0;

    logic       cfg_ack;
    logic [7:0] reloj;
    logic       tick;
    logic [3:0] phase;
    logic       phase_start;
    logic [2:0] level;
    logic [7:0] round;
    logic       running;
    logic       lost;

    sc_gametick_sequencer #(
        .PRESCALE_W    (26),
        .DEFAULT_PERIOD(DEF),
        .MIN_PERIOD    (MINP),
        .SPEEDUP_STEP  (STEP),
        .ROUND_LEN     (RLEN),
        .NUM_BOUNDS    (NB)
    ) dut (
        .SC_GAMESEQ_CLOCK_50         (clk),
        .SC_GAMESEQ_RESET_InLow      (rst_n),
        .SC_GAMESEQ_startButton_InLow(start_n),
        .SC_GAMESEQ_pauseButton_InLow(pause_n),
        .SC_GAMESEQ_collision_InHigh (coll),
        .SC_GAMESEQ_cfgWr_InHigh     (cfg_wr),
        .SC_GAMESEQ_cfgAddr          (cfg_addr),
        .SC_GAMESEQ_cfgData          (cfg_data),
        .SC_GAMESEQ_cfgAck_Out       (cfg_ack),
        .SC_GAMESEQ_reloj_Out        (reloj),
        .SC_GAMESEQ_tick_Out         (tick),
        .SC_GAMESEQ_phase_Out        (phase),
        .SC_GAMESEQ_phaseStart_Out   (phase_start),
        .SC_GAMESEQ_level_Out        (level),
        .SC_GAMESEQ_round_Out        (round),
        .SC_GAMESEQ_running_Out      (running),
        .SC_GAMESEQ_lost_Out         (lost)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef enum int {M_IDLE, M_ARMED, M_RUN, M_PAUSE, M_LOST} mstate_t;
    typedef struct {
        int          cyc;
        logic [25:0] vec;   // {tick, phaseStart, cfgAck, reloj, phase, level, round}
    } pulse_t;

    pulse_t  exp_q[$];
    mstate_t ms        = M_IDLE;
    int      m_reloj   = 0;
    int      m_wraps   = 0;    // rounds completed since the last new game
    int      m_elapsed = 0;    // run cycles since the last counted tick
    int      cyc       = 0;
    bit      m_pprev   = 1'b1;
    int      tbl [NB]  = DEF_TBL;

    function automatic int m_period();
        int p = DEF - m_wraps * STEP;
        return (p < MINP) ? MINP : p;
    endfunction

    // Phase = how many boundaries the count has already reached.
    function automatic int m_phase();
        int n = 0;
        for (int i = 0; i < NB; i++) if (tbl[i] <= m_reloj) n++;
        return n;
    endfunction

    function automatic logic [22:0] m_fields();
        int lv = (m_wraps > 7) ? 7 : m_wraps;
        return {8'(m_reloj), 4'(m_phase()), 3'(lv), 8'(m_wraps % 256)};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit p_tick, p_ps, p_ack, fall;
        int old_ph;
        if (!rst_n) begin
            ms        = M_IDLE;
            m_reloj   = 0;
            m_wraps   = 0;
            m_elapsed = 0;
            m_pprev   = 1'b1;
            for (int i = 0; i < NB; i++) tbl[i] = DEF_TBL[i];
            exp_q.delete();
        end else begin
            cyc++;
            p_tick  = 1'b0;
            p_ps    = 1'b0;
            p_ack   = 1'b0;
            fall    = m_pprev && !pause_n;
            m_pprev = pause_n;
            case (ms)
                M_IDLE: begin
                    if (cfg_wr && cfg_addr < NB) begin
                        tbl[cfg_addr] = cfg_data;
                        p_ack = 1'b1;
                    end
                    if (!start_n) ms = M_ARMED;
                end
                M_ARMED: if (start_n) begin
                    ms = M_RUN; m_reloj = 0; m_elapsed = 0; p_ps = 1'b1;
                end
                M_RUN: begin
                    if (coll) ms = M_LOST;
                    else begin
                        m_elapsed++;
                        if (m_elapsed == m_period()) begin
                            m_elapsed = 0;
                            p_tick    = 1'b1;
                            old_ph    = m_phase();
                            if (m_reloj == RLEN - 1) begin
                                m_reloj = 0; m_wraps++; p_ps = 1'b1;
                            end else begin
                                m_reloj++;
                                if (m_phase() != old_ph) p_ps = 1'b1;
                            end
                        end
                        if (fall) ms = M_PAUSE;
                    end
                end
                M_PAUSE: if (fall) ms = M_RUN;
                M_LOST: if (!start_n) begin ms = M_ARMED; m_wraps = 0; end
                default: ms = M_IDLE;
            endcase
            if (p_tick || p_ps || p_ack) exp_q.push_back('{cyc, {p_tick, p_ps, p_ack, m_fields()}});
        end
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    bit mon_en = 1'b0;

    always @(negedge clk) begin
        pulse_t r;
        if (mon_en) begin
            check("steady_outputs", {running, lost, reloj, phase, level, round},
                  {ms == M_RUN, ms == M_LOST, m_fields()});
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                r = exp_q.pop_front();
                check("pulse", {tick, phase_start, cfg_ack, reloj, phase, level, round}, r.vec);
            end else if (tick || phase_start || cfg_ack) begin
                check("pulse_unexpected", {tick, phase_start, cfg_ack}, 3'b000);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_start();
        start_n = 1'b0;
        cycles(2);
        start_n = 1'b1;
        cycles(1);
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
        cfg_wr = 1'b1; cfg_addr = a; cfg_data = d;
        cycles(1);
        cfg_wr = 1'b0;
        cycles(1);
    endtask

    task automatic wait_reloj(input int target, input string name);
        for (int i = 0; i < 3000 && reloj != 8'(target); i++) @(negedge clk);
        check(name, reloj, target);
    endtask

    task automatic wait_elapsed(input int target);
        for (int i = 0; i < 20 && m_elapsed != target; i++) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cycles(2);
        check("reset_outputs",
              {cfg_ack, reloj, tick, phase, phase_start, level, round, running, lost}, 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        cycles(2);

        // Config writes: accepted in IDLE, rejected out of range
        cfg_write(4'd0, 8'd5);
        cfg_write(4'd9, 8'd77);
        cfg_write(4'd15, 8'd1);

        // Start and run; a write while running must be ignored
        press_start();
        check("running_after_start", running, 1);
        cfg_write(4'd0, 8'd3);
        wait_reloj(5, "reach_reloj5");
        check("phase_at_written_bound", phase, 1);

        // Pause at a mid prescaler count, hold with collisions, resume
        wait_elapsed(2);
        pause_n = 1'b0;
        cycles(1);
        pause_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            coll = (i % 7 == 3);
            cycles(1);
        end
        coll = 1'b0;
        check("paused_not_running", running, 0);
        check("paused_not_lost", lost, 0);
        pause_n = 1'b0;
        cycles(1);
        pause_n = 1'b1;

        // Two wraps: speed-up to period 3, then floor at 2
        wait_reloj(153, "reach_153_first");
        wait_reloj(0, "wrap_first");
        check("round_after_wrap1", round, 1);
        check("level_after_wrap1", level, 1);
        wait_reloj(153, "reach_153_second");
        wait_reloj(0, "wrap_second");
        check("round_after_wrap2", round, 2);
        check("level_after_wrap2", level, 2);
        cycles(30);

        // Collision coincident with a tick at reloj=43
        wait_reloj(43, "reach_43");
        wait_elapsed(m_period() - 1);
        coll = 1'b1;
        cycles(1);
        coll = 1'b0;
        check("collision_reloj_held", reloj, 43);
        check("collision_lost", lost, 1);
        press_start();
        check("restart_level", level, 0);
        check("restart_round", round, 0);
        check("restart_reloj", reloj, 0);
        check("restart_running", running, 1);

        // Asynchronous reset mid-run
        wait_reloj(70, "reach_70");
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs",
                 {cfg_ack, reloj, tick, phase, phase_start, level, round, running, lost}, 0);
        cycles(1);
        rst_n = 1'b1;
        cycles(2);
        press_start();
        wait_reloj(8, "reach_8_defaults");
        check("phase_default_table", phase, 1);

        // Randomised play
        for (int i = 0; i < 1500; i++) begin
            coll     = ($urandom_range(0, 99) == 0);
            pause_n  = ($urandom_range(0, 24) != 0);
            start_n  = ($urandom_range(0, 3) != 0);
            cfg_wr   = ($urandom_range(0, 9) == 0);
            cfg_addr = 4'($urandom_range(0, 15));
            cfg_data = 8'($urandom_range(0, 255));
            cycles(1);
        end
        coll = 1'b0; pause_n = 1'b1; start_n = 1'b1; cfg_wr = 1'b0;
        cycles(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sc_gametick_sequencer.md
Name: sc_gametick_sequencer

Overview:
- Pacing and phase scheduler for the lane-game datapath.
- Divides CLOCK_50 into game ticks and keeps the 8-bit tick count that the lane state machine compares against. Also tracks which phase window the count is in.
- Handles start/pause/collision sequencing, and shortens the tick period after each completed round (level speed-up).
- Phase boundary table is writable from the configuration interface while idle.

Parameters:
- PRESCALE_W, 26, prescaler/period register width.
- DEFAULT_PERIOD, 25000000, CLOCK_50 cycles per tick at level 0 (0.5 s).
- MIN_PERIOD, 3125000, floor for the speed-up.
- SPEEDUP_STEP, 1562500, period reduction per completed round.
- ROUND_LEN, 154, ticks per round; count runs 0..ROUND_LEN-1.
- NUM_BOUNDS, 9, phase boundary table entries.

Ports:
- SC_GAMESEQ_CLOCK_50  in  1  system clock.
- SC_GAMESEQ_RESET_InLow  in  1  asynchronous active-low reset.
- SC_GAMESEQ_startButton_InLow  in  1  debounced start button, low = pressed.
- SC_GAMESEQ_pauseButton_InLow  in  1  debounced pause button, low = pressed.
- SC_GAMESEQ_collision_InHigh  in  1  collision from the lane datapath.
- SC_GAMESEQ_cfgWr_InHigh  in  1  boundary table write strobe.
- SC_GAMESEQ_cfgAddr  in  4  table index.
- SC_GAMESEQ_cfgData  in  8  boundary value.
- SC_GAMESEQ_cfgAck_Out  out  1  one-cycle write-accepted pulse.
- SC_GAMESEQ_reloj_Out  out  8  tick count.
- SC_GAMESEQ_tick_Out  out  1  one-cycle pulse per counted tick.
- SC_GAMESEQ_phase_Out  out  4  current phase index, 0..NUM_BOUNDS.
- SC_GAMESEQ_phaseStart_Out  out  1  one-cycle pulse on phase entry.
- SC_GAMESEQ_level_Out  out  3  speed level, saturates at 7.
- SC_GAMESEQ_round_Out  out  8  completed rounds, wraps at 255->0.
- SC_GAMESEQ_running_Out  out  1  high in RUN.
- SC_GAMESEQ_lost_Out  out  1  high in LOST.

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE.
  - All outputs 0.
  - Prescaler 0, period=DEFAULT_PERIOD.
  - Table loaded with defaults 8,24,44,52,60,90,98,106,146.
  - Pause edge-detect register=1.
- Reset mid-run aborts immediately; no pulse is emitted.
- States:
  - IDLE: start low -> ARMED.
  - ARMED: waits for start high -> RUN. On entry to RUN: reloj=0, phase=0, prescaler=0, phaseStart pulses once.
  - RUN: collision high -> LOST at the next edge. Pause falling edge (registered previous=1, current=0) -> PAUSE.
  - PAUSE: prescaler and counters frozen; collision ignored. Next pause falling edge -> RUN, prescaler resumes from its held value.
  - LOST: counters frozen, lost=1. Start low -> ARMED.
  - ARMED entered from LOST: level=0, round=0, period=DEFAULT_PERIOD.
- Tick (RUN only):
  - Prescaler increments each cycle. When it reaches period-1 it clears, tick pulses, and reloj increments.
  - reloj, tick and phaseStart update in the same cycle; latency is 1 clock after the terminal prescaler count.
- Phase:
  - On a tick, if phase<NUM_BOUNDS and the new reloj equals bound[phase]: phase+1 and phaseStart pulses.
  - Bounds are to be written strictly increasing; behaviour with non-increasing tables is don't-care but must not lock up.
- Wrap:
  - A tick with reloj=ROUND_LEN-1 sets reloj=0, phase=0, pulses phaseStart, increments round, and increments level (saturating at 7).
  - Same wrap: period = max(period-SPEEDUP_STEP, MIN_PERIOD), taking effect from the next tick.
- Simultaneous events:
  - Collision has priority over tick, wrap and pause in the same cycle: that tick is not counted and no pulses are emitted.
  - Pause edge and tick in the same cycle: the tick is counted, then the block pauses.
- Config:
  - cfgWr is accepted only in IDLE with cfgAddr<NUM_BOUNDS. The entry is written and cfgAck pulses the next cycle.
  - Any other write is ignored, with no ack.
- Output mapping: running=(state==RUN); lost=(state==LOST).

Test Plan:
1. DEFAULT_PERIOD=4. Press then release start -> running=1 and phaseStart pulses; tick every 4 clocks; reloj 0,1,2...; at reloj=8, phase=1 with a phaseStart pulse.
2. Run to reloj=153, next tick -> reloj=0, phase=0, round=1, level=1. Period becomes 3 (MIN_PERIOD=2, STEP=1); after one more wrap the period stays at 2.
3. Assert collision in the same cycle as the tick at reloj=43 -> reloj stays 43, no tick pulse, lost=1 next clock. Start press/release -> level=0, round=0, reloj=0, running=1.
4. Pause falling edge at a mid prescaler count -> reloj frozen for 50 clocks and collision ignored. Second falling edge -> the next tick arrives after the remaining prescaler count.
5. In IDLE write addr 0 = 5 -> cfgAck pulses. Write in RUN or to addr 9 -> no ack, table unchanged. After start, phase increments at reloj=5.
6. Assert reset low mid-RUN at reloj=70 -> all outputs 0 immediately (asynchronous), state IDLE, table back to defaults.
